// File: rtl/freq_display_pkg.sv
// rtl/freq_display_pkg.sv - shared segment codes, decode function and conversion FSM states
package freq_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // gfedcba, active-low
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/freq_display_bin2bcd_seq.sv
// rtl/freq_display_bin2bcd_seq.sv - sequential shift-add-3 binary to 4-digit BCD converter
module bin2bcd_seq
  import freq_display_pkg::*;
#(
  parameter int BIN_W = 12
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state, state_nxt;
  logic [BIN_W-1:0] bin_q;
  logic [15:0]      bcd_q;
  logic [15:0]      bcd_adj;
  logic [CNT_W-1:0] cnt_q;

  assign bcd = bcd_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1))
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q <= value;
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/freq_display.sv
// rtl/freq_display.sv - change-triggered BCD conversion driving a 4-digit multiplexed 7-seg display
module freq_display
  import freq_display_pkg::*;
#(
  parameter int BIN_W       = 12,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [BIN_W-1:0] FREQ,
  output logic [6:0]       SEG,
  output logic             DP,
  output logic [3:0]       AN,
  output logic             BUSY
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [BIN_W-1:0]  last_conv;
  logic [BIN_W-1:0]  conv_val;
  logic [15:0]       digits;
  logic [15:0]       conv_bcd;
  logic              conv_done;
  logic              start;
  logic [RCNT_W-1:0] refresh_cnt;
  logic [1:0]        digit_idx;
  logic [3:0]        cur_digit;
  logic [3:0]        lead_zero;

  assign DP    = 1'b1;
  // BUSY is low only in IDLE, so this also gates FREQ changes during a conversion
  assign start = !BUSY && (FREQ != last_conv);

  bin2bcd_seq #(
    .BIN_W(BIN_W)
  ) u_bin2bcd (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start),
    .value (FREQ),
    .busy  (BUSY),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_conv <= '0;
      conv_val  <= '0;
      digits    <= '0;
    end else begin
      if (start)
        conv_val <= FREQ;
      if (conv_done) begin
        digits    <= conv_bcd;
        last_conv <= conv_val;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RCNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // a digit blanks only when it and every higher digit are zero
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (digits[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (digits[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (digits[7:4] == 4'd0);
    cur_digit    = digits[{digit_idx, 2'b00} +: 4];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      SEG <= SEG_BLANK;
      AN  <= 4'hF;
    end else begin
      SEG <= lead_zero[digit_idx] ? SEG_BLANK : seg_decode(cur_digit);
      AN  <= ~(4'b0001 << digit_idx);
    end
  end

endmodule

// File: tb/tb_freq_display.sv
// tb/tb_freq_display.sv - self-checking bench for freq_display with a decimal reference model
module tb_freq_display;

  localparam int BIN_W       = 12;
  localparam int REFRESH_DIV = 4;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [BIN_W-1:0] FREQ;
  logic [6:0]       SEG;
  logic             DP;
  logic [3:0]       AN;
  logic             BUSY;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         pow10   [4]  = '{1, 10, 100, 1000};

  freq_display #(
    .BIN_W       (BIN_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .FREQ  (FREQ),
    .SEG   (SEG),
    .DP    (DP),
    .AN    (AN),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int val, input int slot);
    if (slot > 0 && val < pow10[slot])
      return 7'h7F;
    return seg_tab[(val / pow10[slot]) % 10];
  endfunction

  function automatic int an_slot(input logic [3:0] an);
    case (an)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  // one full scan round: order, segment contents, DP and BUSY quiet
  task automatic check_display(input int val);
    int prev;
    int slot;
    int busy_cnt;
    int seen [4];
    prev     = -1;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    for (int c = 0; c < 4 * REFRESH_DIV; c++) begin
      tick();
      slot = an_slot(AN);
      if (slot < 0) begin
        chk("an_onehot", {28'd0, AN}, 32'hE);
      end else begin
        chk($sformatf("seg val=%0d slot=%0d", val, slot), {25'd0, SEG}, {25'd0, exp_seg(val, slot)});
        if (prev >= 0 && slot != prev)
          chk("an_order", slot, (prev + 1) % 4);
        prev       = slot;
        seen[slot] = 1;
      end
      if (BUSY) busy_cnt++;
    end
    chk("dp_off", {31'd0, DP}, 32'd1);
    for (int i = 0; i < 4; i++) chk($sformatf("slot_seen%0d", i), seen[i], 1);
    chk("busy_quiet", busy_cnt, 0);
  endtask

  task automatic measure_busy(output int len);
    int w;
    w = 0;
    while (!BUSY && w < 8) begin
      tick();
      w++;
    end
    chk("busy_rise", {31'd0, BUSY}, 32'd1);
    len = 0;
    while (BUSY && len < 100) begin
      len++;
      tick();
    end
  endtask

  initial begin
    int len;
    int len2;
    int gap;
    int cur;
    int v;
    int slot;

    RST_N = 1'b0;
    FREQ  = '0;
    tick(); tick(); tick();
    chk("rst_seg",  {25'd0, SEG},  32'h7F);
    chk("rst_an",   {28'd0, AN},   32'hF);
    chk("rst_dp",   {31'd0, DP},   32'd1);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);

    RST_N = 1'b1;
    check_display(0);
    check_display(0);

    FREQ = 12'd4095;
    measure_busy(len);
    chk("busy_len_4095", len, 13);
    check_display(4095);

    FREQ = 12'd7;
    measure_busy(len);
    chk("busy_len_7", len, 13);
    check_display(7);

    // value change mid-conversion is deferred to the cycle after DONE
    FREQ = 12'd100;
    len  = 0;
    gap  = 0;
    while (!BUSY && gap < 8) begin tick(); gap++; end
    chk("busy_rise_100", {31'd0, BUSY}, 32'd1);
    while (BUSY && len < 100) begin
      len++;
      if (len == 5) FREQ = 12'd250;
      tick();
    end
    chk("busy_len_100", len, 13);
    gap = 0;
    while (!BUSY && gap < 10) begin gap++; tick(); end
    chk("idle_gap", gap, 1);
    len2 = 0;
    while (BUSY && len2 < 100) begin
      len2++;
      if (len2 == 3) begin
        slot = an_slot(AN);
        chk("mid_slot_valid", {31'd0, slot >= 0}, 32'd1);
        if (slot >= 0)
          chk("seg_100_during_2nd", {25'd0, SEG}, {25'd0, exp_seg(100, slot)});
      end
      tick();
    end
    chk("busy_len_250", len2, 13);
    check_display(250);

    // reset during a conversion discards it; 3000 reconverts from last_conv=0
    FREQ = 12'd3000;
    len  = 0;
    gap  = 0;
    while (!BUSY && gap < 8) begin tick(); gap++; end
    chk("busy_rise_3000", {31'd0, BUSY}, 32'd1);
    while (BUSY && len < 6) begin
      len++;
      if (len < 6) tick();
    end
    RST_N = 1'b0;
    tick();
    chk("midrst_seg",  {25'd0, SEG},  32'h7F);
    chk("midrst_an",   {28'd0, AN},   32'hF);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    RST_N = 1'b1;
    measure_busy(len);
    chk("busy_len_3000", len, 13);
    check_display(3000);

    FREQ = 12'd1234;
    measure_busy(len);
    chk("busy_len_1234", len, 13);
    check_display(1234);
    check_display(1234);
    check_display(1234);

    cur = 1234;
    for (int n = 0; n < 6; n++) begin
      v = int'($urandom_range(0, 4095));
      if (v == cur) v = (v + 1) % 4096;
      FREQ = BIN_W'(v);
      measure_busy(len);
      chk($sformatf("busy_len_rand%0d", v), len, 13);
      check_display(v);
      cur = v;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
